lfsr32_chk: RTL and testbench
=============================

// Module: lfsr32_chk
// PURPOSE
//  Receive-side checker for the 32-bit LFSR stream produced by lfsr32_e.
//  Samples the generator's 32-bit state word on each enabled cycle and predicts
//  the next word. It self-synchronises (hunts), then reports mismatches and
//  lock status. Sits at the sink end of the hwpq_test stimulus path; BIST-style link check.
// PARAMETERS
//  SYNC_CNT    4    consecutive correct predictions required to declare lock (1..15)
//  LOSS_CNT    3    consecutive mismatches while locked that force re-hunt (1..15)
//  ERRW        16   width of saturating error counter
// PORTS
//  clk       in   1     system clock, rising edge
//  rst_n     in   1     asynchronous active-low reset
//  enb       in   1     d is valid this cycle (mirrors generator enb)
//  d         in   32    received LFSR state word
//  clr_cnt   in   1     synchronous clear of err_cnt and bit_err_cnt
//  locked    out  1     checker in LOCK state
//  err       out  1     one-cycle pulse: sampled word mismatched prediction while locked
//  err_cnt   out  ERRW  saturating count of mismatched words while locked
//  bit_err_cnt out 32   saturating count of mismatched bits (see CONFIGURATION)
// BEHAVIOUR
//  - Step function: nxt(q) = {q[30:0], q[31]^q[21]^q[1]^q[0]} (taps 32,22,2,1).
//  - Reset (rst_n=0, async): state=HUNT, pred=0, run=0, locked=0, err=0,
//    err_cnt=0, bit_err_cnt=0.
//  - Cycles with enb=0: no state, pred or counter change; err=0.
//  - HUNT: on enb, if d==0 (lock-up word): run=0, pred unchanged.
//    Else if run!=0 and d==pred: run++. Otherwise run=1.
//    Always pred<=nxt(d) (d nonzero). When run reaches SYNC_CNT -> LOCK;
//    err never asserts in HUNT.
//  - LOCK: on enb, compare d with pred. Match: pred<=nxt(pred), miss=0.
//    Mismatch: err=1 next cycle, err_cnt++ (saturate at all-ones),
//    pred<=nxt(pred) (free-run; no reload from d), miss++.
//    miss reaching LOSS_CNT -> HUNT, run=0, locked=0.
//  - locked, err, err_cnt are registered: visible the cycle after the deciding sample.
//  - clr_cnt has priority over a same-cycle increment (counter reads 0 after).
//    State, pred and locked are unaffected by clr_cnt.
//  - Reset mid-operation: immediate return to reset values; a re-lock needs a new
//    SYNC_CNT run.
// CONFIGURATION
//  LFSR32_CHK_BITERR_EN defined: on each locked mismatch,
//    bit_err_cnt += popcount(d^pred), saturating at 32'hFFFF_FFFF; cleared by clr_cnt.
//  Undefined: bit_err_cnt tied to 32'h0; no popcount logic is built.
// STRUCTURE
//  lfsr32_pkg: localparam LFSR32_TAPS, function lfsr32_next(), and
//    typedef enum logic [0:0] {HUNT, LOCK} chk_state_t.
//  Sub-module popcnt32 (32-in, 6-out combinational popcount) is instantiated only
//    under LFSR32_CHK_BITERR_EN.
//  Step logic uses the package function so it cannot drift from lfsr32_e.
// TESTING
//  1 Reset: rst_n=0 mid-sim with enb=1 -> all outputs 0 asynchronously, state HUNT.
//  2 Sync: enb=1, d=32'h1,32'h3,32'h6,... (from lfsr32_e) -> locked=1 the cycle
//    after the 5th sample (SYNC_CNT=4); err=0 throughout.
//  3 Single error: after lock, replace one word with its bit0 inverted ->
//    one err pulse, err_cnt=1, locked stays 1, and the next word matches.
//    With LFSR32_CHK_BITERR_EN, bit_err_cnt=1.
//  4 Loss: after lock, drive 3 consecutive wrong words -> err_cnt=3, locked=0.
//    Correct stream resumed -> re-lock after 5 samples.
//  5 Enable gaps: toggle enb 1/0 each cycle with d changing during enb=0 ->
//    no errors, lock retained; d=0 in HUNT never produces lock.
//  6 Counters: force err_cnt to saturate (ERRW=4 build, 20 errors) -> holds 4'hF.
//    clr_cnt on the same cycle as an error -> 0.

Source files
------------

// File: rtl/lfsr32_pkg.sv
// Shared LFSR32 definitions: tap mask, step function and checker state type.
package lfsr32_pkg;

  // Feedback taps 32,22,2,1 expressed as bit positions 31,21,1,0.
  localparam logic [31:0] LFSR32_TAPS = 32'h8020_0003;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } chk_state_t;

  // One generator step; shared with lfsr32_e so both ends agree.
  function automatic logic [31:0] lfsr32_next(input logic [31:0] q);
    return {q[30:0], ^(q & LFSR32_TAPS)};
  endfunction

endpackage

// File: rtl/popcnt32.sv
// 32-bit combinational population count.
// Only compiled when LFSR32_CHK_BITERR_EN is defined (bit-error counting).
`ifdef LFSR32_CHK_BITERR_EN
module popcnt32 (
  input  logic [31:0] i_data,
  output logic [5:0]  o_count_c
);

  // Sum of set bits.
  always_comb begin
    o_count_c = '0;
    for (int i = 0; i < 32; i++) begin
      o_count_c = o_count_c + 6'(i_data[i]);
    end
  end

endmodule
`endif

// File: rtl/lfsr32_chk.sv
// Receive-side checker for the lfsr32_e stream: hunts for sync, then flags
// mismatched words while locked.
// Optional feature macro: LFSR32_CHK_BITERR_EN enables the bit-error counter.
module lfsr32_chk
  import lfsr32_pkg::*;
#(
  parameter int unsigned SYNC_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned ERRW     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enb,
  input  logic [31:0]     d,
  input  logic            clr_cnt,
  output logic            locked,
  output logic            err,
  output logic [ERRW-1:0] err_cnt,
  output logic [31:0]     bit_err_cnt
);

  localparam int unsigned CNTW = 4;

  chk_state_t      r_state;
  logic [31:0]     r_pred;
  logic [CNTW-1:0] r_run;
  logic [CNTW-1:0] r_miss;
  logic            r_locked;
  logic            r_err;
  logic [ERRW-1:0] r_err_cnt;

  chk_state_t      w_state_nxt;
  logic [31:0]     w_pred_nxt;
  logic [CNTW-1:0] w_run_nxt;
  logic [CNTW-1:0] w_miss_nxt;
  logic [CNTW-1:0] w_miss_inc;
  logic            w_err_nxt;
  logic            w_err_inc;
  logic            w_match;
  logic [ERRW-1:0] w_err_cnt_nxt;

  assign w_match    = (d == r_pred);
  assign w_miss_inc = r_miss + CNTW'(1);

  // Next-state, prediction and run/miss tracking.
  // Lock is declared once SYNC_CNT predictions in a row have been confirmed,
  // i.e. on the (SYNC_CNT+1)-th consecutive chained word.
  always_comb begin
    w_state_nxt = r_state;
    w_pred_nxt  = r_pred;
    w_run_nxt   = r_run;
    w_miss_nxt  = r_miss;
    w_err_nxt   = 1'b0;
    w_err_inc   = 1'b0;
    if (enb) begin
      case (r_state)
        HUNT: begin
          if (d == 32'h0) begin
            w_run_nxt = '0;
          end else begin
            w_pred_nxt = lfsr32_next(d);
            if ((r_run != '0) && w_match) begin
              if (r_run == CNTW'(SYNC_CNT)) begin
                w_state_nxt = LOCK;
                w_run_nxt   = '0;
                w_miss_nxt  = '0;
              end else begin
                w_run_nxt = r_run + CNTW'(1);
              end
            end else begin
              w_run_nxt = CNTW'(1);
            end
          end
        end
        LOCK: begin
          // Free-run the prediction; a bad word never reloads it.
          w_pred_nxt = lfsr32_next(r_pred);
          if (w_match) begin
            w_miss_nxt = '0;
          end else begin
            w_err_nxt = 1'b1;
            w_err_inc = 1'b1;
            if (w_miss_inc == CNTW'(LOSS_CNT)) begin
              w_state_nxt = HUNT;
              w_run_nxt   = '0;
              w_miss_nxt  = '0;
            end else begin
              w_miss_nxt = w_miss_inc;
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  // Saturating word-error counter; clear wins over increment.
  always_comb begin
    w_err_cnt_nxt = r_err_cnt;
    if (clr_cnt) begin
      w_err_cnt_nxt = '0;
    end else if (w_err_inc && (r_err_cnt != {ERRW{1'b1}})) begin
      w_err_cnt_nxt = r_err_cnt + ERRW'(1);
    end
  end

  // Checker state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= HUNT;
      r_pred    <= '0;
      r_run     <= '0;
      r_miss    <= '0;
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pred    <= w_pred_nxt;
      r_run     <= w_run_nxt;
      r_miss    <= w_miss_nxt;
      r_locked  <= (w_state_nxt == LOCK);
      r_err     <= w_err_nxt;
      r_err_cnt <= w_err_cnt_nxt;
    end
  end

`ifdef LFSR32_CHK_BITERR_EN
  logic [31:0] w_diff;
  logic [5:0]  w_pop;
  logic [32:0] w_bec_sum;
  logic [31:0] w_bec_nxt;
  logic [31:0] r_bit_err_cnt;

  assign w_diff = d ^ r_pred;

  popcnt32 u_popcnt32 (
    .i_data    (w_diff),
    .o_count_c (w_pop)
  );

  // Saturating accumulation of differing bits on locked mismatches.
  always_comb begin
    w_bec_sum = {1'b0, r_bit_err_cnt} + 33'(w_pop);
    w_bec_nxt = r_bit_err_cnt;
    if (clr_cnt) begin
      w_bec_nxt = '0;
    end else if (w_err_inc) begin
      w_bec_nxt = w_bec_sum[32] ? 32'hFFFF_FFFF : w_bec_sum[31:0];
    end
  end

  // Bit-error counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_err_cnt <= '0;
    end else begin
      r_bit_err_cnt <= w_bec_nxt;
    end
  end

  assign bit_err_cnt = r_bit_err_cnt;
`else
  assign bit_err_cnt = 32'h0;
`endif

  assign locked  = r_locked;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_lfsr32_chk.sv
// Self-checking bench for lfsr32_chk (ERRW=4 so saturation is reachable).
module tb_lfsr32_chk;

  localparam int unsigned ERRW = 4;
  localparam int unsigned SYNC = 4;
  localparam int unsigned LOSS = 3;
`ifdef LFSR32_CHK_BITERR_EN
  localparam bit BEC_EN = 1'b1;
`else
  localparam bit BEC_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enb = 1'b0;
  logic [31:0]     d = '0;
  logic            clr_cnt = 1'b0;
  logic            locked;
  logic            err;
  logic [ERRW-1:0] err_cnt;
  logic [31:0]     bit_err_cnt;

  int n_pass = 0;
  int n_total = 0;

  lfsr32_chk #(.SYNC_CNT(SYNC), .LOSS_CNT(LOSS), .ERRW(ERRW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enb         (enb),
    .d           (d),
    .clr_cnt     (clr_cnt),
    .locked      (locked),
    .err         (err),
    .err_cnt     (err_cnt),
    .bit_err_cnt (bit_err_cnt)
  );

  always #5 clk = ~clk;

  // Generator step from the polynomial x^32+x^22+x^2+x+1.
  function automatic logic [31:0] ref_next(input logic [31:0] q);
    logic fb;
    fb = q[31] ^ q[21] ^ q[1] ^ q[0];
    return (q << 1) | {31'd0, fb};
  endfunction

  // k-th word of the stream starting at 1.
  function automatic logic [31:0] seqw(input int k);
    logic [31:0] q;
    q = 32'h1;
    for (int i = 0; i < k; i++) q = ref_next(q);
    return q;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step(input logic e, input logic [31:0] dd, input logic c);
    enb = e;
    d = dd;
    clr_cnt = c;
    @(posedge clk);
    #1;
  endtask

  // Reference model: hunting as a chain of successive stream words.
  logic [31:0] hq[$];
  logic        m_locked;
  logic        m_err;
  logic [31:0] m_pred;
  int          m_miss;
  int          m_cnt;
  longint      m_bec;

  task automatic m_reset();
    hq.delete();
    m_locked = 0; m_err = 0; m_pred = 0; m_miss = 0; m_cnt = 0; m_bec = 0;
  endtask

  task automatic m_step(input logic e, input logic [31:0] dd, input logic c);
    m_err = 0;
    if (e) begin
      if (!m_locked) begin
        if (dd == 0) hq.delete();
        else if (hq.size() != 0 && dd == ref_next(hq[$])) hq.push_back(dd);
        else begin hq.delete(); hq.push_back(dd); end
        if (hq.size() == SYNC + 1) begin
          m_locked = 1; m_pred = ref_next(dd); m_miss = 0; hq.delete();
        end
      end else begin
        if (dd == m_pred) m_miss = 0;
        else begin
          m_err = 1;
          if (m_cnt < (1 << ERRW) - 1) m_cnt++;
          if (BEC_EN) begin
            m_bec += $countones(dd ^ m_pred);
            if (m_bec > 64'hFFFF_FFFF) m_bec = 64'hFFFF_FFFF;
          end
          m_miss++;
          if (m_miss == LOSS) begin m_locked = 0; m_miss = 0; hq.delete(); end
        end
        m_pred = ref_next(m_pred);
      end
    end
    if (c) begin m_cnt = 0; m_bec = 0; end
  endtask

  typedef struct {
    logic        enb;
    logic [31:0] d;
    logic        clr;
    logic        el;
    logic        ee;
    logic [3:0]  ec;
    logic [31:0] eb;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int k;
    logic [31:0] w;

    // Directed table from reset: sync, single errors, clear priority, loss, re-lock.
    tbl[0]  = '{1, seqw(0), 0, 0, 0, 0, 0};
    tbl[1]  = '{1, seqw(1), 0, 0, 0, 0, 0};
    tbl[2]  = '{1, seqw(2), 0, 0, 0, 0, 0};
    tbl[3]  = '{1, seqw(3), 0, 0, 0, 0, 0};
    tbl[4]  = '{1, seqw(4), 0, 1, 0, 0, 0};
    tbl[5]  = '{0, 32'hDEAD_BEEF, 0, 1, 0, 0, 0};
    tbl[6]  = '{1, seqw(5), 0, 1, 0, 0, 0};
    tbl[7]  = '{1, seqw(6) ^ 32'h1, 0, 1, 1, 1, 1};
    tbl[8]  = '{1, seqw(7), 0, 1, 0, 1, 1};
    tbl[9]  = '{0, 32'h0, 0, 1, 0, 1, 1};
    tbl[10] = '{1, seqw(8) ^ 32'h1, 1, 1, 1, 0, 0};
    tbl[11] = '{1, seqw(9), 0, 1, 0, 0, 0};
    tbl[12] = '{1, seqw(10) ^ 32'h2, 0, 1, 1, 1, 1};
    tbl[13] = '{1, seqw(11) ^ 32'h4, 0, 1, 1, 2, 2};
    tbl[14] = '{1, seqw(12) ^ 32'h18, 0, 0, 1, 3, 4};
    tbl[15] = '{1, seqw(13), 0, 0, 0, 3, 4};
    tbl[16] = '{1, seqw(14), 0, 0, 0, 3, 4};
    tbl[17] = '{1, seqw(15), 0, 0, 0, 3, 4};
    tbl[18] = '{1, seqw(16), 0, 0, 0, 3, 4};
    tbl[19] = '{1, seqw(17), 0, 1, 0, 3, 4};

    #3;
    chk("reset_locked", {31'd0, locked}, 32'd0);
    chk("reset_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].enb, tbl[i].d, tbl[i].clr);
      chk($sformatf("tbl%0d_locked", i), {31'd0, locked}, {31'd0, tbl[i].el});
      chk($sformatf("tbl%0d_err", i), {31'd0, err}, {31'd0, tbl[i].ee});
      chk($sformatf("tbl%0d_err_cnt", i), 32'(err_cnt), 32'(tbl[i].ec));
      chk($sformatf("tbl%0d_bit_err_cnt", i), bit_err_cnt, BEC_EN ? tbl[i].eb : 32'h0);
    end

    // Asynchronous reset mid-stream with enb high.
    enb = 1'b1; d = seqw(18);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_locked", {31'd0, locked}, 32'd0);
    chk("async_rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("async_rst_bec", bit_err_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Re-lock after reset needs a fresh run of five words.
    for (int i = 0; i < 5; i++) begin
      step(1, seqw(18 + i), 0);
      chk($sformatf("relock%0d", i), {31'd0, locked}, {31'd0, (i == 4)});
    end

    // Enable gaps with junk on d while locked.
    k = 23;
    for (int i = 0; i < 8; i++) begin
      step(0, $urandom, 0);
      step(1, seqw(k), 0);
      k++;
      chk($sformatf("gap%0d_err", i), {31'd0, err}, 32'd0);
    end
    chk("gap_locked", {31'd0, locked}, 32'd1);

    // Zero words in HUNT never lock, and a zero breaks a chain.
    rst_n = 1'b0; #1; rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1, 32'h0, 0);
    chk("zero_nolock", {31'd0, locked}, 32'd0);
    step(1, seqw(0), 0);
    step(1, seqw(1), 0);
    step(1, 32'h0, 0);
    for (int i = 2; i < 6; i++) step(1, seqw(i), 0);
    chk("zero_break_nolock", {31'd0, locked}, 32'd0);
    step(1, seqw(6), 0);
    chk("zero_break_lock", {31'd0, locked}, 32'd1);

    // Saturation: 20 errors interleaved with good words.
    k = 7;
    for (int i = 0; i < 20; i++) begin
      w = seqw(k) ^ 32'h8000_0000;
      step(1, w, 0);
      step(1, seqw(k + 1), 0);
      k += 2;
    end
    chk("sat_err_cnt", 32'(err_cnt), 32'hF);
    chk("sat_locked", {31'd0, locked}, 32'd1);
    step(1, seqw(k) ^ 32'h1, 1);
    chk("clr_err_pulse", {31'd0, err}, 32'd1);
    chk("clr_priority", 32'(err_cnt), 32'd0);
    chk("clr_bec", bit_err_cnt, 32'd0);

    // Randomized stream against the reference model.
    begin
      logic [31:0] g;
      logic        e, c;
      logic [31:0] dd;
      int          r;
      rst_n = 1'b0;
      step(0, 0, 0);
      rst_n = 1'b1;
      m_reset();
      g = $urandom | 32'h1;
      for (int i = 0; i < 3000; i++) begin
        e = ($urandom_range(3) != 0);
        c = ($urandom_range(49) == 0);
        dd = $urandom;
        if (e) begin
          r = $urandom_range(99);
          if (r < 85) begin dd = g; g = ref_next(g); end
          else if (r < 92) begin dd = g ^ ($urandom | 32'h1); g = ref_next(g); end
          else if (r < 95) dd = 32'h0;
          else begin g = $urandom | 32'h1; dd = g; g = ref_next(g); end
        end
        step(e, dd, c);
        m_step(e, dd, c);
        if (locked !== m_locked || err !== m_err ||
            err_cnt !== ERRW'(m_cnt) || bit_err_cnt !== 32'(m_bec) || (i % 100) == 0) begin
          chk($sformatf("rnd%0d_locked", i), {31'd0, locked}, {31'd0, m_locked});
          chk($sformatf("rnd%0d_err", i), {31'd0, err}, {31'd0, m_err});
          chk($sformatf("rnd%0d_err_cnt", i), 32'(err_cnt), 32'(m_cnt));
          chk($sformatf("rnd%0d_bec", i), bit_err_cnt, 32'(m_bec));
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
